// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: one position/speed update per video frame.
// Decodes W/A/S/D from a packed multi-slot USB keycode bus, ramps the step size
// from StepMin to StepMax while a direction is held, and keeps the sprite centre
// inside the screen.
// Optional feature macro: SPRITE_SCREEN_WRAP_EN
//   undefined - centre is clamped to [Min+Size, Max-Size] on each axis
//   defined   - leaving that range jumps the centre to the opposite bound and
//               at_edge_o is tied to zero
module sprite_motion_ctrl #(
  parameter int unsigned PosW        = 10,
  parameter int unsigned XMin        = 0,
  parameter int unsigned XMax        = 639,
  parameter int unsigned YMin        = 0,
  parameter int unsigned YMax        = 479,
  parameter int unsigned XStart      = 320,
  parameter int unsigned YStart      = 240,
  parameter int unsigned Size        = 8,
  parameter int unsigned StepMin     = 1,
  parameter int unsigned StepMax     = 4,
  parameter int unsigned AccelFrames = 4,
  parameter int unsigned KeySlots    = 2,
  localparam int unsigned SpeedW     = $clog2(StepMax + 1)
) (
  input  logic                  frame_clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [8*KeySlots-1:0] keycode_i,
  output logic [PosW-1:0]       pos_x_o,
  output logic [PosW-1:0]       pos_y_o,
  output logic [PosW-1:0]       size_o,
  output logic [SpeedW-1:0]     speed_o,
  output logic                  moving_o,
  output logic [3:0]            at_edge_o
);

  // USB HID usage codes for the movement keys
  localparam logic [7:0] KeyW = 8'h1A;
  localparam logic [7:0] KeyA = 8'h04;
  localparam logic [7:0] KeyS = 8'h16;
  localparam logic [7:0] KeyD = 8'h07;

  localparam int unsigned CntW = (AccelFrames > 1) ? $clog2(AccelFrames) : 1;
  localparam logic [CntW-1:0] AccelLast = CntW'(AccelFrames - 1);

  localparam logic [SpeedW-1:0] StepMinS  = SpeedW'(StepMin);
  localparam logic [SpeedW-1:0] StepMaxS  = SpeedW'(StepMax);
  localparam logic [SpeedW:0]   StepMaxW  = (SpeedW + 1)'(StepMax);
  // A degenerate ramp (no acceleration) skips straight to cruising
  localparam bit                NoRamp    = (StepMin >= StepMax);

  // Legal centre range, both as signed sums for bounding and as output-width values
  localparam logic signed [PosW+1:0] XLoS = (PosW + 2)'(XMin + Size);
  localparam logic signed [PosW+1:0] XHiS = (PosW + 2)'(XMax - Size);
  localparam logic signed [PosW+1:0] YLoS = (PosW + 2)'(YMin + Size);
  localparam logic signed [PosW+1:0] YHiS = (PosW + 2)'(YMax - Size);
  localparam logic [PosW-1:0]        XLo  = PosW'(XMin + Size);
  localparam logic [PosW-1:0]        XHi  = PosW'(XMax - Size);
  localparam logic [PosW-1:0]        YLo  = PosW'(YMin + Size);
  localparam logic [PosW-1:0]        YHi  = PosW'(YMax - Size);

  typedef enum logic [1:0] {
    StIdle,
    StAccel,
    StCruise
  } state_e;

  state_e            state_q, state_d;
  logic [SpeedW-1:0] speed_q, speed_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        dx_q, dy_q;
  logic [PosW-1:0]   pos_x_q, pos_x_d;
  logic [PosW-1:0]   pos_y_q, pos_y_d;
  logic [3:0]        at_edge_q, at_edge_d;

  logic              w_hit, a_hit, s_hit, d_hit;
  logic [1:0]        dx, dy;
  logic              dir_active, dir_changed;
  logic [SpeedW:0]   speed_inc;

  logic signed [PosW+1:0] spd_s, step_x, step_y, sum_x, sum_y;

  // Map an out-of-range sum back into the legal centre range
  function automatic logic [PosW-1:0] bound_axis(input logic signed [PosW+1:0] sum,
                                                 input logic signed [PosW+1:0] lo,
                                                 input logic signed [PosW+1:0] hi);
    logic signed [PosW+1:0] r;
    r = sum;
`ifdef SPRITE_SCREEN_WRAP_EN
    // Jump to the opposite bound; the excess distance is discarded on purpose
    if (sum < lo) begin
      r = hi;
    end else if (sum > hi) begin
      r = lo;
    end
`else
    if (sum < lo) begin
      r = lo;
    end else if (sum > hi) begin
      r = hi;
    end
`endif
    return r[PosW-1:0];
  endfunction

  // Key decode: a key is pressed if any slot carries its code
  always_comb begin
    w_hit = 1'b0;
    a_hit = 1'b0;
    s_hit = 1'b0;
    d_hit = 1'b0;
    for (int i = 0; i < int'(KeySlots); i++) begin
      if (keycode_i[8*i +: 8] == KeyW) w_hit = 1'b1;
      if (keycode_i[8*i +: 8] == KeyA) a_hit = 1'b1;
      if (keycode_i[8*i +: 8] == KeyS) s_hit = 1'b1;
      if (keycode_i[8*i +: 8] == KeyD) d_hit = 1'b1;
    end
  end

  // Per-axis direction as 2-bit two's complement: opposing keys cancel
  always_comb begin
    dx = 2'b00;
    dy = 2'b00;
    if (d_hit && !a_hit) dx = 2'b01;
    if (a_hit && !d_hit) dx = 2'b11;
    if (s_hit && !w_hit) dy = 2'b01;
    if (w_hit && !s_hit) dy = 2'b11;
  end

  assign dir_active  = (dx != 2'b00) || (dy != 2'b00);
  assign dir_changed = (dx != dx_q) || (dy != dy_q);
  assign speed_inc   = {1'b0, speed_q} + (SpeedW + 1)'(1);

  // Speed ramp FSM next state; any new direction restarts the ramp at StepMin
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        speed_d = '0;
        cnt_d   = '0;
        if (dir_active) begin
          speed_d = StepMinS;
          state_d = NoRamp ? StCruise : StAccel;
        end
      end
      StAccel: begin
        if (!dir_active) begin
          state_d = StIdle;
          speed_d = '0;
          cnt_d   = '0;
        end else if (dir_changed) begin
          state_d = NoRamp ? StCruise : StAccel;
          speed_d = StepMinS;
          cnt_d   = '0;
        end else if (cnt_q == AccelLast) begin
          cnt_d   = '0;
          speed_d = speed_inc[SpeedW-1:0];
          if (speed_inc >= StepMaxW) begin
            state_d = StCruise;
            speed_d = StepMaxS;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCruise: begin
        cnt_d = '0;
        if (!dir_active) begin
          state_d = StIdle;
          speed_d = '0;
        end else if (dir_changed) begin
          state_d = NoRamp ? StCruise : StAccel;
          speed_d = StepMinS;
        end else begin
          speed_d = StepMaxS;
        end
      end
      default: begin
        state_d = StIdle;
        speed_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Position next state: move by the speed chosen on this same edge (zero latency)
  always_comb begin
    spd_s  = $signed({{(PosW + 2 - SpeedW){1'b0}}, speed_d});
    step_x = '0;
    step_y = '0;
    if (dx == 2'b01) step_x = spd_s;
    if (dx == 2'b11) step_x = -spd_s;
    if (dy == 2'b01) step_y = spd_s;
    if (dy == 2'b11) step_y = -spd_s;
    // Two guard bits keep the sum from wrapping below 0 or past 2^PosW
    sum_x   = $signed({2'b00, pos_x_q}) + step_x;
    sum_y   = $signed({2'b00, pos_y_q}) + step_y;
    pos_x_d = bound_axis(sum_x, XLoS, XHiS);
    pos_y_d = bound_axis(sum_y, YLoS, YHiS);
  end

  // Edge flags follow the new centre: {top, bottom, left, right}
  always_comb begin
`ifdef SPRITE_SCREEN_WRAP_EN
    at_edge_d = 4'b0000;
`else
    at_edge_d = {(pos_y_d == YLo), (pos_y_d == YHi), (pos_x_d == XLo), (pos_x_d == XHi)};
`endif
  end

  // All state advances together, and only on enabled frames
  always_ff @(posedge frame_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      speed_q   <= '0;
      cnt_q     <= '0;
      dx_q      <= 2'b00;
      dy_q      <= 2'b00;
      pos_x_q   <= PosW'(XStart);
      pos_y_q   <= PosW'(YStart);
      at_edge_q <= 4'b0000;
    end else if (enable_i) begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      dx_q      <= dx;
      dy_q      <= dy;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      at_edge_q <= at_edge_d;
    end
  end

  assign pos_x_o   = pos_x_q;
  assign pos_y_o   = pos_y_q;
  assign size_o    = PosW'(Size);
  assign speed_o   = speed_q;
  assign moving_o  = (state_q != StIdle);
  assign at_edge_o = at_edge_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl (default parameters).
// Honours SPRITE_SCREEN_WRAP_EN so the same bench covers both bound modes.
module tb_sprite_motion_ctrl;

  localparam int STEP_MIN = 1;
  localparam int STEP_MAX = 4;
  localparam int ACCEL    = 4;
  localparam int XLO = 8, XHI = 631, YLO = 8, YHI = 471;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] keycode;
  logic [9:0]  pos_x, pos_y, size;
  logic [2:0]  speed;
  logic        moving;
  logic [3:0]  at_edge;

  int n_vec;
  int n_err;

  // Reference model state: speed follows from how long one direction has been held
  int m_px, m_py, m_spd, m_run, m_ldx, m_ldy;

  sprite_motion_ctrl dut (
    .frame_clk_i (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .keycode_i   (keycode),
    .pos_x_o     (pos_x),
    .pos_y_o     (pos_y),
    .size_o      (size),
    .speed_o     (speed),
    .moving_o    (moving),
    .at_edge_o   (at_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] key;
    int          spd;
    int          px;
    int          py;
    int          mv;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bound(input int v, input int lo, input int hi);
`ifdef SPRITE_SCREEN_WRAP_EN
    if (v < lo) return hi;
    if (v > hi) return lo;
`else
    if (v < lo) return lo;
    if (v > hi) return hi;
`endif
    return v;
  endfunction

  function automatic int model_edge();
`ifdef SPRITE_SCREEN_WRAP_EN
    return 0;
`else
    return ((m_py == YLO) ? 8 : 0) + ((m_py == YHI) ? 4 : 0) +
           ((m_px == XLO) ? 2 : 0) + ((m_px == XHI) ? 1 : 0);
`endif
  endfunction

  task automatic model_reset();
    m_px = 320; m_py = 240; m_spd = 0; m_run = 0; m_ldx = 0; m_ldy = 0;
  endtask

  task automatic model_step(input logic [15:0] key, input logic en);
    int dx, dy;
    bit w, a, s, d;
    logic [7:0] b;
    if (en) begin
      w = 0; a = 0; s = 0; d = 0;
      for (int i = 0; i < 2; i++) begin
        b = key[8*i +: 8];
        if (b == 8'h1A) w = 1;
        if (b == 8'h04) a = 1;
        if (b == 8'h16) s = 1;
        if (b == 8'h07) d = 1;
      end
      dx = int'(d) - int'(a);
      dy = int'(s) - int'(w);
      if (dx == 0 && dy == 0) begin
        m_run = 0;
        m_spd = 0;
      end else begin
        if (m_run == 0 || dx != m_ldx || dy != m_ldy) m_run = 1;
        else if (m_run < 100000) m_run++;
        m_spd = STEP_MIN + (m_run - 1) / ACCEL;
        if (m_spd > STEP_MAX) m_spd = STEP_MAX;
      end
      m_ldx = dx;
      m_ldy = dy;
      m_px = bound(m_px + dx * m_spd, XLO, XHI);
      m_py = bound(m_py + dy * m_spd, YLO, YHI);
    end
  endtask

  // Drive one frame: inputs change 1 time unit after an edge, outputs sampled likewise
  task automatic step_frame(input logic [15:0] key, input logic en);
    keycode = key;
    enable  = en;
    @(posedge clk);
    model_step(key, en);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".speed"}, int'(speed), m_spd);
    chk({tag, ".pos_x"}, int'(pos_x), m_px);
    chk({tag, ".pos_y"}, int'(pos_y), m_py);
    chk({tag, ".moving"}, int'(moving), (m_spd != 0) ? 1 : 0);
    chk({tag, ".at_edge"}, int'(at_edge), model_edge());
  endtask

  function automatic logic [7:0] rand_code();
    case ($urandom_range(0, 7))
      0, 1:    return 8'h00;
      2:       return 8'h1A;
      3:       return 8'h04;
      4:       return 8'h16;
      5:       return 8'h07;
      6:       return 8'h2C;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int px_prev;
    int len;
    logic [15:0] k;
    logic en;

    n_vec = 0;
    n_err = 0;

    // Expected trace for hold-D ramp, release, diagonal and cancelling pairs
    for (int i = 0; i < 12; i++) begin
      tbl[i].key = 16'h0007;
      tbl[i].spd = 1 + i / 4;
      tbl[i].py  = 240;
      tbl[i].mv  = 1;
    end
    tbl[0].px = 321;  tbl[1].px = 322;  tbl[2].px = 323;  tbl[3].px = 324;
    tbl[4].px = 326;  tbl[5].px = 328;  tbl[6].px = 330;  tbl[7].px = 332;
    tbl[8].px = 335;  tbl[9].px = 338;  tbl[10].px = 341; tbl[11].px = 344;
    tbl[12] = '{16'h0000, 0, 344, 240, 0};
    tbl[13] = '{16'h1A04, 1, 343, 239, 1};
    tbl[14] = '{16'h1A04, 1, 342, 238, 1};
    tbl[15] = '{16'h1A16, 0, 342, 238, 0};
    tbl[16] = '{16'h2C00, 0, 342, 238, 0};
    tbl[17] = '{16'h0716, 1, 343, 239, 1};
    tbl[18] = '{16'h0704, 0, 343, 239, 0};

    // Reset state
    rst_n   = 1'b0;
    enable  = 1'b1;
    keycode = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pos_x", int'(pos_x), 320);
    chk("reset.pos_y", int'(pos_y), 240);
    chk("reset.speed", int'(speed), 0);
    chk("reset.moving", int'(moving), 0);
    chk("reset.at_edge", int'(at_edge), 0);
    chk("size", int'(size), 8);
    rst_n = 1'b1;

    // Idle frames with no keys
    repeat (10) step_frame(16'h0000, 1'b1);
    chk("idle10.pos_x", int'(pos_x), 320);
    chk("idle10.pos_y", int'(pos_y), 240);
    chk("idle10.speed", int'(speed), 0);
    chk("idle10.moving", int'(moving), 0);

    // Table-driven vectors
    for (int i = 0; i < 19; i++) begin
      step_frame(tbl[i].key, 1'b1);
      chk($sformatf("tbl%0d.speed", i), int'(speed), tbl[i].spd);
      chk($sformatf("tbl%0d.pos_x", i), int'(pos_x), tbl[i].px);
      chk($sformatf("tbl%0d.pos_y", i), int'(pos_y), tbl[i].py);
      chk($sformatf("tbl%0d.moving", i), int'(moving), tbl[i].mv);
      chk($sformatf("tbl%0d.at_edge", i), int'(at_edge), 0);
    end

    // Right bound: from reset, 83 frames of D reach x=628 at cruise speed
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (83) step_frame(16'h0007, 1'b1);
    chk("edge.pre_x", int'(pos_x), 628);
    chk("edge.pre_speed", int'(speed), 4);
    step_frame(16'h0007, 1'b1);
`ifdef SPRITE_SCREEN_WRAP_EN
    chk("edge.x", int'(pos_x), 8);
    chk("edge.flags", int'(at_edge), 0);
`else
    chk("edge.x", int'(pos_x), 631);
    chk("edge.flags", int'(at_edge), 1);
`endif
    step_frame(16'h0007, 1'b1);
    chk("edge.hold_speed", int'(speed), 4);
    check_model("edge.hold");

    // Cruising right then reverse: ramp restarts at 1 on the switch frame
    px_prev = m_px;
    step_frame(16'h0004, 1'b1);
    chk("rev.speed", int'(speed), 1);
    chk("rev.pos_x", int'(pos_x), px_prev - 1);
    chk("rev.moving", int'(moving), 1);

    // Freeze: enable low with a new key held leaves everything untouched
    px_prev = m_px;
    repeat (5) step_frame(16'h0007, 1'b0);
    chk("freeze.pos_x", int'(pos_x), px_prev);
    chk("freeze.speed", int'(speed), 1);
    check_model("freeze");
    step_frame(16'h0007, 1'b1);
    chk("unfreeze.speed", int'(speed), 1);
    chk("unfreeze.pos_x", int'(pos_x), px_prev + 1);

    // Asynchronous reset mid-frame, no clock edge needed
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset.pos_x", int'(pos_x), 320);
    chk("areset.pos_y", int'(pos_y), 240);
    chk("areset.speed", int'(speed), 0);
    chk("areset.moving", int'(moving), 0);
    chk("areset.at_edge", int'(at_edge), 0);
    keycode = 16'h0007;
    @(posedge clk);
    #1;
    chk("areset.held_x", int'(pos_x), 320);
    rst_n = 1'b1;
    step_frame(16'h0000, 1'b1);
    check_model("post_reset.idle");
    step_frame(16'h0007, 1'b1);
    chk("post_reset.first_x", int'(pos_x), 321);
    check_model("post_reset.first");

    // Randomised holds against the model, long enough to reach every bound
    for (int seg = 0; seg < 70; seg++) begin
      k   = {rand_code(), rand_code()};
      len = $urandom_range(1, 120);
      for (int j = 0; j < len; j++) begin
        en = ($urandom_range(0, 9) != 0);
        step_frame(k, en);
        check_model($sformatf("rnd%0d_%0d", seg, j));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
